// File: rtl/cosine_sim.sv
// ---------------------------------------------------------------------------
// cosine_sim
//   Sequential cosine-similarity engine: similarity = (A.B) / (|A| * |B|)
//   over two W-element signed Q16.15 vectors. One element is accumulated per
//   cycle (MAC), then both norms are square-rooted bit-serially in parallel,
//   multiplied once, and a bit-serial restoring divider produces the Q15
//   quotient.
//
//   Optional build macro: COSINE_SIM_SATURATE_EN
//     defined   -> result clamped to [-1.0, +1.0] (-32768 .. +32768)
//     undefined -> raw signed quotient written
//
// Ports
//   clk             clock, rising edge
//   rst             synchronous active-high reset
//   start           1-cycle pulse, accepted in IDLE or DONE
//   vec_a, vec_b    W signed Q16.15 elements each, stable from start to valid
//   similarity      signed Q15 result (1.0 = 32768)
//   valid           high while in DONE
//   index           element currently accumulated in MAC
//   state           FSM state code (IDLE=0 MAC=1 SQRT=2 MUL=3 DIV=4 DONE=5)
//   dot_prod        low 32 bits of vec_a[index]*vec_b[index] this cycle
//   dot_prod_accum  low 32 bits of the dot-product accumulator
//   dot_prod_o      final dot product >>> FRAC, latched on MAC exit
// ---------------------------------------------------------------------------
module cosine_sim #(
    parameter int W    = 5,
    parameter int FRAC = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [31:0] vec_a [W],
    input  logic signed [31:0] vec_b [W],
    output logic signed [31:0] similarity,
    output logic               valid,
    output logic [2:0]         index,
    output logic [2:0]         state,
    output logic signed [31:0] dot_prod,
    output logic signed [31:0] dot_prod_accum,
    output logic signed [31:0] dot_prod_o
);
    localparam logic [2:0]  S_IDLE    = 3'd0;
    localparam logic [2:0]  S_MAC     = 3'd1;
    localparam logic [2:0]  S_SQRT    = 3'd2;
    localparam logic [2:0]  S_MUL     = 3'd3;
    localparam logic [2:0]  S_DIV     = 3'd4;
    localparam logic [2:0]  S_DONE    = 3'd5;
    localparam logic [2:0]  IDX_LAST  = 3'(W - 1);
    localparam logic [5:0]  SQRT_LAST = 6'd33;
    localparam logic [5:0]  DIV_LAST  = 6'd16;
    localparam logic [16:0] ONE_Q     = 17'(1 << FRAC);
    localparam int          NW        = 67 + FRAC;

    logic [2:0]         state_r, state_next_s;
    logic               load_s, mac_en_s, sqrt_en_s, mul_en_s, div_en_s, valid_next_s;
    logic [2:0]         index_r;
    logic [5:0]         cnt_r;
    logic signed [66:0] dot_acc_r;
    logic [66:0]        na_acc_r, nb_acc_r;
    logic signed [31:0] dot_q15_r;
    logic [67:0]        rad_a_r, rad_b_r;
    logic [34:0]        rem_a_r, rem_b_r;
    logic [33:0]        root_a_r, root_b_r;
    logic [67:0]        den_r;
    logic [67:0]        div_rem_r;
    logic [16:0]        div_low_r;
    logic [16:0]        quot_r;
    logic signed [31:0] sim_r;
    logic               valid_r;

    logic signed [31:0] a_sel_s, b_sel_s;
    logic signed [63:0] prod_s, sq_a_s, sq_b_s;
    logic signed [66:0] dot_fin_s;
    logic [66:0]        na_fin_s, nb_fin_s;
    logic signed [31:0] dot_q15_s;
    logic [34:0]        sq_rem_a_s, sq_rem_b_s;
    logic [33:0]        sq_root_a_s, sq_root_b_s;
    logic               root_zero_s;
    logic [66:0]        dot_abs_s;
    logic [NW-1:0]      num_s;
    logic [68:0]        div_sh_s;
    logic [67:0]        div_rem_next_s;
    logic [16:0]        quot_next_s, q_sat_s;
    logic signed [31:0] mag_s, sim_next_s;

    // One restoring square-root step: bring down two radicand bits, try
    // subtracting (4*root + 1); the remainder never exceeds 2*root so 35 bits hold it.
    function automatic logic [68:0] sqrt_step(input logic [34:0] rem,
                                              input logic [32:0] root,
                                              input logic [1:0]  pair);
        logic [36:0] rem_sh;
        logic [36:0] trial;
        rem_sh = {rem, pair};
        trial  = {2'b00, root, 2'b01};
        if (rem_sh >= trial) begin
            sqrt_step = {35'(rem_sh - trial), root, 1'b1};
        end else begin
            sqrt_step = {35'(rem_sh), root, 1'b0};
        end
    endfunction

    assign a_sel_s   = vec_a[index_r];
    assign b_sel_s   = vec_b[index_r];
    assign prod_s    = a_sel_s * b_sel_s;
    assign sq_a_s    = a_sel_s * a_sel_s;
    assign sq_b_s    = b_sel_s * b_sel_s;
    assign dot_fin_s = dot_acc_r + {{3{prod_s[63]}}, prod_s};
    assign na_fin_s  = na_acc_r + {3'b000, sq_a_s};
    assign nb_fin_s  = nb_acc_r + {3'b000, sq_b_s};
    assign dot_q15_s = 32'(dot_fin_s >>> FRAC);

    assign {sq_rem_a_s, sq_root_a_s} = sqrt_step(rem_a_r, root_a_r[32:0], rad_a_r[67:66]);
    assign {sq_rem_b_s, sq_root_b_s} = sqrt_step(rem_b_r, root_b_r[32:0], rad_b_r[67:66]);
    assign root_zero_s = (root_a_r == 34'd0) || (root_b_r == 34'd0);

    // The quotient is known to fit 17 bits, so the divider starts with the
    // numerator's upper part already in the remainder and shifts in the low 17.
    assign dot_abs_s = dot_acc_r[66] ? -dot_acc_r : dot_acc_r;
    assign num_s     = {dot_abs_s, {FRAC{1'b0}}};
    assign div_sh_s  = {div_rem_r, div_low_r[16]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) state_next_s = S_MAC;
                else       state_next_s = state_r;
            end
            S_MAC: begin
                if (index_r == IDX_LAST) state_next_s = S_SQRT;
                else                     state_next_s = S_MAC;
            end
            S_SQRT: begin
                if (cnt_r == SQRT_LAST) state_next_s = S_MUL;
                else                    state_next_s = S_SQRT;
            end
            S_MUL: begin
                if (root_zero_s) state_next_s = S_DONE;
                else             state_next_s = S_DIV;
            end
            S_DIV: begin
                if (cnt_r == DIV_LAST) state_next_s = S_DONE;
                else                   state_next_s = S_DIV;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Output decode: datapath enables per state
    always_comb begin
        load_s    = 1'b0;
        mac_en_s  = 1'b0;
        sqrt_en_s = 1'b0;
        mul_en_s  = 1'b0;
        div_en_s  = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: load_s    = start;
            S_MAC:          mac_en_s  = 1'b1;
            S_SQRT:         sqrt_en_s = 1'b1;
            S_MUL:          mul_en_s  = 1'b1;
            S_DIV:          div_en_s  = 1'b1;
            default:        load_s    = 1'b0;
        endcase
        valid_next_s = (state_next_s == S_DONE);
    end

    // Divider step, optional clamp and sign restore
    always_comb begin
        if (div_sh_s >= {1'b0, den_r}) begin
            div_rem_next_s = 68'(div_sh_s - {1'b0, den_r});
            quot_next_s    = {quot_r[15:0], 1'b1};
        end else begin
            div_rem_next_s = 68'(div_sh_s);
            quot_next_s    = {quot_r[15:0], 1'b0};
        end
`ifdef COSINE_SIM_SATURATE_EN
        if (quot_next_s > ONE_Q) q_sat_s = ONE_Q;
        else                     q_sat_s = quot_next_s;
`else
        q_sat_s = quot_next_s;
`endif
        mag_s = {15'd0, q_sat_s};
        if (dot_acc_r[66]) sim_next_s = -mag_s;
        else               sim_next_s = mag_s;
    end

    // Datapath: accumulators, sqrt/divide iterations, result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r   <= 1'b0;
            index_r   <= 3'd0;
            cnt_r     <= 6'd0;
            dot_acc_r <= 67'sd0;
            na_acc_r  <= 67'd0;
            nb_acc_r  <= 67'd0;
            dot_q15_r <= 32'sd0;
            rad_a_r   <= 68'd0;
            rad_b_r   <= 68'd0;
            rem_a_r   <= 35'd0;
            rem_b_r   <= 35'd0;
            root_a_r  <= 34'd0;
            root_b_r  <= 34'd0;
            den_r     <= 68'd0;
            div_rem_r <= 68'd0;
            div_low_r <= 17'd0;
            quot_r    <= 17'd0;
            sim_r     <= 32'sd0;
        end else begin
            valid_r <= valid_next_s;
            if (load_s) begin
                dot_acc_r <= 67'sd0;
                na_acc_r  <= 67'd0;
                nb_acc_r  <= 67'd0;
                index_r   <= 3'd0;
            end else if (mac_en_s) begin
                dot_acc_r <= dot_fin_s;
                na_acc_r  <= na_fin_s;
                nb_acc_r  <= nb_fin_s;
                if (index_r == IDX_LAST) begin
                    index_r   <= 3'd0;
                    dot_q15_r <= dot_q15_s;
                    rad_a_r   <= {1'b0, na_fin_s};
                    rad_b_r   <= {1'b0, nb_fin_s};
                    rem_a_r   <= 35'd0;
                    rem_b_r   <= 35'd0;
                    root_a_r  <= 34'd0;
                    root_b_r  <= 34'd0;
                    cnt_r     <= 6'd0;
                end else begin
                    index_r <= index_r + 3'd1;
                end
            end else if (sqrt_en_s) begin
                rad_a_r  <= {rad_a_r[65:0], 2'b00};
                rad_b_r  <= {rad_b_r[65:0], 2'b00};
                rem_a_r  <= sq_rem_a_s;
                rem_b_r  <= sq_rem_b_s;
                root_a_r <= sq_root_a_s;
                root_b_r <= sq_root_b_s;
                cnt_r    <= cnt_r + 6'd1;
            end else if (mul_en_s) begin
                den_r     <= root_a_r * root_b_r;
                div_rem_r <= 68'(num_s >> 17);
                div_low_r <= num_s[16:0];
                quot_r    <= 17'd0;
                cnt_r     <= 6'd0;
                if (root_zero_s) sim_r <= 32'sd0;
            end else if (div_en_s) begin
                div_rem_r <= div_rem_next_s;
                div_low_r <= {div_low_r[15:0], 1'b0};
                quot_r    <= quot_next_s;
                cnt_r     <= cnt_r + 6'd1;
                if (cnt_r == DIV_LAST) sim_r <= sim_next_s;
            end
        end
    end

    assign similarity     = sim_r;
    assign valid          = valid_r;
    assign index          = index_r;
    assign state          = state_r;
    assign dot_prod       = prod_s[31:0];
    assign dot_prod_accum = dot_acc_r[31:0];
    assign dot_prod_o     = dot_q15_r;
endmodule

// File: tb/tb_cosine_sim.sv
// ---------------------------------------------------------------------------
// tb_cosine_sim
//   Table-driven bench for cosine_sim (W=5, FRAC=15): each record holds both
//   input vectors plus the hand-computed similarity, Q15 dot product and
//   start-to-valid cycle count. Hand-written sequences cover reset values,
//   MAC debug taps, reset mid-computation and a start pulse that must be
//   ignored while busy.
// ---------------------------------------------------------------------------
module tb_cosine_sim;
    localparam int W   = 5;
    localparam int ONE = 32768;
    localparam int NV  = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [31:0] vec_a [W];
    logic signed [31:0] vec_b [W];
    logic signed [31:0] similarity;
    logic               valid;
    logic [2:0]         index;
    logic [2:0]         state;
    logic signed [31:0] dot_prod;
    logic signed [31:0] dot_prod_accum;
    logic signed [31:0] dot_prod_o;

    cosine_sim #(.W(W), .FRAC(15)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .vec_a          (vec_a),
        .vec_b          (vec_b),
        .similarity     (similarity),
        .valid          (valid),
        .index          (index),
        .state          (state),
        .dot_prod       (dot_prod),
        .dot_prod_accum (dot_prod_accum),
        .dot_prod_o     (dot_prod_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0][31:0] a;
        logic [W-1:0][31:0] b;
        logic [31:0]        sim;
        logic [31:0]        dotq;
        logic [7:0]         lat;
        logic [1:0]         tol;
    } vec_t;

    vec_t vecs [NV];
    int   tests = 0;
    int   fails = 0;
    int   lat;

    function automatic logic [W-1:0][31:0] pk(input int e0, input int e1, input int e2,
                                              input int e3, input int e4);
        logic [W-1:0][31:0] p;
        p[0] = 32'(e0 * ONE);
        p[1] = 32'(e1 * ONE);
        p[2] = 32'(e2 * ONE);
        p[3] = 32'(e3 * ONE);
        p[4] = 32'(e4 * ONE);
        return p;
    endfunction

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp, input int tol);
        longint diff;
        diff = longint'(act) - longint'(exp);
        if (diff < 0) diff = -diff;
        tests++;
        if (diff > longint'(tol)) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic apply(input int k);
        for (int i = 0; i < W; i++) begin
            vec_a[i] = vecs[k].a[i];
            vec_b[i] = vecs[k].b[i];
        end
    endtask

    // Pulse start, then count rising edges (including the one sampling
    // start) until valid is seen; optionally re-pulse start while busy.
    task automatic run(input int poke_at, output int cycles);
        int n;
        n      = 0;
        cycles = -1;
        start  = 1'b1;
        while (cycles < 0 && n < 200) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (valid) cycles = n;
            else if (n == poke_at) start = 1'b1;
        end
    endtask

    initial begin
        vecs[0] = '{a: pk(1, 1, 1, 1, 1), b: pk(1, 1, 1, 1, 1),
                    sim: 32'(32768), dotq: 32'(163840), lat: 8'd58, tol: 2'd0};
        vecs[1] = '{a: pk(1, 1, 1, 1, 1), b: pk(-1, -1, -1, -1, -1),
                    sim: 32'(-32768), dotq: 32'(-163840), lat: 8'd58, tol: 2'd0};
        vecs[2] = '{a: pk(1, 0, 0, 0, 0), b: pk(0, 1, 0, 0, 0),
                    sim: 32'(0), dotq: 32'(0), lat: 8'd58, tol: 2'd0};
        vecs[3] = '{a: pk(0, 0, 0, 0, 0), b: pk(1, 2, 3, 4, 5),
                    sim: 32'(0), dotq: 32'(0), lat: 8'd41, tol: 2'd0};
        vecs[4] = '{a: pk(3, 4, 0, 0, 0), b: pk(4, 3, 0, 0, 0),
                    sim: 32'(31457), dotq: 32'(786432), lat: 8'd58, tol: 2'd1};
        vecs[5] = '{a: pk(2, 0, 0, 0, 0), b: pk(-1, 1, 0, 0, 0),
                    sim: 32'(-23170), dotq: 32'(-65536), lat: 8'd58, tol: 2'd1};

        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            vec_a[i] = 32'sd0;
            vec_b[i] = 32'sd0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset state",      32'(state),     32'sd0, 0);
        check("reset valid",      32'(valid),     32'sd0, 0);
        check("reset similarity", similarity,     32'sd0, 0);
        check("reset index",      32'(index),     32'sd0, 0);
        check("reset accum",      dot_prod_accum, 32'sd0, 0);
        check("reset dot_o",      dot_prod_o,     32'sd0, 0);

        // Table: vector k+1 starts straight from DONE of vector k
        for (int k = 0; k < NV; k++) begin
            apply(k);
            run(0, lat);
            check($sformatf("v%0d latency", k), 32'(lat), 32'(vecs[k].lat), 0);
            check($sformatf("v%0d state", k), 32'(state), 32'sd5, 0);
            check($sformatf("v%0d similarity", k), similarity, vecs[k].sim, int'(vecs[k].tol));
            check($sformatf("v%0d dot_prod_o", k), dot_prod_o, vecs[k].dotq, 0);
        end

        // Result held in DONE without a new start
        repeat (3) @(posedge clk);
        #1;
        check("done hold valid", 32'(valid), 32'sd1, 0);
        check("done hold sim",   similarity, vecs[NV-1].sim, 1);

        // MAC debug taps, then reset at index 2
        apply(0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("mac0 state",    32'(state),     32'sd1, 0);
        check("mac0 index",    32'(index),     32'sd0, 0);
        check("mac0 dot_prod", dot_prod,       32'h4000_0000, 0);
        check("mac0 accum",    dot_prod_accum, 32'sd0, 0);
        @(posedge clk);
        #1;
        check("mac1 index",    32'(index),     32'sd1, 0);
        check("mac1 accum",    dot_prod_accum, 32'h4000_0000, 0);
        @(posedge clk);
        #1;
        check("mac2 index",    32'(index),     32'sd2, 0);
        check("mac2 accum",    dot_prod_accum, 32'h8000_0000, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort state",      32'(state),     32'sd0, 0);
        check("abort valid",      32'(valid),     32'sd0, 0);
        check("abort similarity", similarity,     32'sd0, 0);
        check("abort index",      32'(index),     32'sd0, 0);
        check("abort accum",      dot_prod_accum, 32'sd0, 0);
        run(0, lat);
        check("restart latency",    32'(lat),   32'sd58, 0);
        check("restart similarity", similarity, 32'sd32768, 0);

        // start pulsed during SQRT must be ignored
        apply(4);
        run(10, lat);
        check("busy start latency", 32'(lat),   32'sd58, 0);
        check("busy start sim",     similarity, 32'sd31457, 1);
        check("busy start dot_o",   dot_prod_o, 32'sd786432, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
